// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//   - opcode encodings OP_ADD..OP_RSVD (3-bit CMD_OP values)
//   - FSM state encoding IDLE/EXEC/MUL_ITER/MUL_FIN/RESP
//   - MUL_ITERS: number of shift-add iterations for an 8-bit multiply
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_CMP  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam int MUL_ITERS = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    MUL_ITER = 3'd2,
    MUL_FIN  = 3'd3,
    RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command and response handshake bundle of the sequencer.
//   Command : CMD_VALID, CMD_READY, CMD_OP[2:0], CMD_SET_FLAGS, CMD_A, CMD_B
//   Response: RSP_VALID, RSP_READY, RSP_DATA, RSP_WE, RSP_ERR
//   master = decode side (issues commands, consumes responses)
//   slave  = alu_sequencer
interface alu_sequencer_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic       CMD_SET_FLAGS;
  logic [7:0] CMD_A;
  logic [7:0] CMD_B;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic [7:0] RSP_DATA;
  logic       RSP_WE;
  logic       RSP_ERR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_SET_FLAGS, CMD_A, CMD_B, RSP_READY,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_WE, RSP_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_SET_FLAGS, CMD_A, CMD_B, RSP_READY,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_WE, RSP_ERR
  );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// alu_seq_mul_iter: iteration state for the shift-add multiply.
//   Holds the partial product P, the shifted multiplicand A<<i and bit index i.
//   Ports: CLK, RST_N (async, active-low); i_start loads A and clears P/i;
//   i_step advances one iteration, taking i_alu_result (P + A<<i) into P when
//   i_b[i] is set; o_p / o_a_sh drive the ALU operands; o_last flags i==7.
module alu_seq_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic [WIDTH-1:0] o_p,
  output logic [WIDTH-1:0] o_a_sh,
  output logic             o_last
);

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_a_sh;
  logic [2:0]       r_idx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_p    <= '0;
      r_a_sh <= '0;
      r_idx  <= '0;
    end else if (i_start) begin
      r_p    <= '0;
      r_a_sh <= i_a;
      r_idx  <= '0;
    end else if (i_step) begin
      // The ALU always adds; the sum is kept only when this multiplier bit is set.
      if (i_b[r_idx]) r_p <= i_alu_result;
      r_a_sh <= r_a_sh << 1;
      r_idx  <= r_idx + 3'd1;
    end
  end

  assign o_p    = r_p;
  assign o_a_sh = r_a_sh;
  assign o_last = (r_idx == 3'(MUL_ITERS - 1));

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one command at a time to an 8-bit ALU datapath and
// returns the captured ALU_RESULT over a valid/ready response port.
//   CLK, RST_N      : clock, asynchronous active-low reset
//   bus (slave)     : CMD_* command handshake, RSP_* response handshake
//   BUSY            : state is not IDLE
//   ALU_ADD/SUB/SHIFT/OR/AND/SETFLAGS : ALU strobes
//   ALU_ACC, ALU_REG: ALU operands; ALU_RESULT: combinational ALU result
// Build option: define ALU_SEQ_MUL_EN to build the shift-add multiply (op 6);
// without it op 6 is answered as an illegal opcode.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  alu_sequencer_if.slave   bus,
  output logic             BUSY,
  output logic             ALU_ADD,
  output logic             ALU_SUB,
  output logic             ALU_SHIFT,
  output logic             ALU_OR,
  output logic             ALU_AND,
  output logic             ALU_SETFLAGS,
  output logic [WIDTH-1:0] ALU_ACC,
  output logic [WIDTH-1:0] ALU_REG,
  input  logic [WIDTH-1:0] ALU_RESULT
);

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_rsp_data;
  logic             r_setf, r_rsp_we, r_rsp_err;

  logic             w_accept, w_load, w_rsp_we, w_rsp_err;
  logic [WIDTH-1:0] w_rsp_data, w_p, w_a_sh;
  logic             w_mul_last;

  assign w_accept      = bus.CMD_VALID && (r_state == IDLE);
  assign bus.CMD_READY = (r_state == IDLE);
  assign bus.RSP_VALID = (r_state == RESP);
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_WE    = r_rsp_we;
  assign bus.RSP_ERR   = r_rsp_err;
  assign BUSY          = (r_state != IDLE);

`ifdef ALU_SEQ_MUL_EN
  logic w_mul_start, w_mul_step;
  assign w_mul_start = w_accept && (bus.CMD_OP == OP_MUL);
  assign w_mul_step  = (r_state == MUL_ITER);

  // A is taken straight from the command bus at accept so the first
  // iteration already sees A<<0.
  alu_seq_mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_start      (w_mul_start),
    .i_step       (w_mul_step),
    .i_a          (bus.CMD_A),
    .i_b          (r_b),
    .i_alu_result (ALU_RESULT),
    .o_p          (w_p),
    .o_a_sh       (w_a_sh),
    .o_last       (w_mul_last)
  );
`else
  assign w_p        = '0;
  assign w_a_sh     = '0;
  assign w_mul_last = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_rsp_data   = '0;
    w_rsp_we     = 1'b0;
    w_rsp_err    = 1'b0;
    ALU_ADD      = 1'b0;
    ALU_SUB      = 1'b0;
    ALU_SHIFT    = 1'b0;
    ALU_OR       = 1'b0;
    ALU_AND      = 1'b0;
    ALU_SETFLAGS = 1'b0;
    ALU_ACC      = '0;
    ALU_REG      = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.CMD_OP == OP_RSVD) begin
            w_next    = RESP;
            w_load    = 1'b1;
            w_rsp_err = 1'b1;
          end else if (bus.CMD_OP == OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
            w_next    = MUL_ITER;
`else
            w_next    = RESP;
            w_load    = 1'b1;
            w_rsp_err = 1'b1;
`endif
          end else begin
            w_next = EXEC;
          end
        end
      end
      EXEC: begin
        w_next       = RESP;
        w_load       = 1'b1;
        w_rsp_data   = ALU_RESULT;
        w_rsp_we     = (r_op != OP_CMP);
        // CMP exists only for its flags, so it always updates them.
        ALU_SETFLAGS = r_setf || (r_op == OP_CMP);
        case (r_op)
          OP_ADD: begin ALU_ADD = 1'b1; ALU_ACC = r_a; ALU_REG = r_b; end
          // The ALU computes REG-ACC, so operands are swapped to get A-B.
          OP_SUB, OP_CMP: begin ALU_SUB = 1'b1; ALU_ACC = r_b; ALU_REG = r_a; end
          OP_SHR: begin ALU_SHIFT = 1'b1; ALU_REG = r_a; end
          OP_OR:  begin ALU_OR  = 1'b1; ALU_ACC = r_a; ALU_REG = r_b; end
          OP_AND: begin ALU_AND = 1'b1; ALU_ACC = r_a; ALU_REG = r_b; end
          default: ;
        endcase
      end
      MUL_ITER: begin
        ALU_ADD = 1'b1;
        ALU_ACC = w_p;
        ALU_REG = w_a_sh;
        if (w_mul_last) w_next = MUL_FIN;
      end
      MUL_FIN: begin
        // P + 0 pass-through so the flags reflect the final product.
        ALU_ADD      = 1'b1;
        ALU_ACC      = w_p;
        ALU_SETFLAGS = r_setf;
        w_next       = RESP;
        w_load       = 1'b1;
        w_rsp_data   = ALU_RESULT;
        w_rsp_we     = 1'b1;
      end
      RESP: begin
        if (bus.RSP_READY) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_setf     <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_we   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.CMD_OP;
        r_a    <= bus.CMD_A;
        r_b    <= bus.CMD_B;
        r_setf <= bus.CMD_SET_FLAGS;
      end
      if (w_load) begin
        r_rsp_data <= w_rsp_data;
        r_rsp_we   <= w_rsp_we;
        r_rsp_err  <= w_rsp_err;
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Issues one command at a time to the 8-bit ALU datapath.
- Each command is one of: add, subtract, shift, OR, AND, compare, multiply.
- Drives the ALU control strobes and operands, captures `ALU_RESULT`, and returns it over a valid/ready response port.
- Sits between instruction decode and the ALU. Single-cycle ops take one ALU cycle; multiply is a shift-add loop run through the ALU adder.

## Interface
Parameters:
- `WIDTH`, 8, datapath width; only 8 is supported.

Ports:
- `CLK` in 1: the only clock.
- `RST_N` in 1: reset, asynchronous and active-low.
- `CMD_VALID` in 1: a command is offered.
- `CMD_READY` out 1: the block accepts a command; high only in IDLE.
- `CMD_OP` in 3: 0 ADD, 1 SUB, 2 SHR, 3 OR, 4 AND, 5 CMP, 6 MUL, 7 reserved.
- `CMD_SET_FLAGS` in 1: update ALU flags for this command.
- `CMD_A`, `CMD_B` in 8 each: operands.
- `RSP_VALID` out 1: a response is held.
- `RSP_READY` in 1: the consumer accepts the response.
- `RSP_DATA` out 8: result.
- `RSP_WE` out 1: the result is to be written back; 0 for CMP and error.
- `RSP_ERR` out 1: illegal opcode.
- `BUSY` out 1: state is not IDLE.
- `ALU_ADD`, `ALU_SUB`, `ALU_SHIFT`, `ALU_OR`, `ALU_AND`, `ALU_SETFLAGS` out 1 each: ALU strobes.
- `ALU_ACC`, `ALU_REG` out 8 each: ALU operands.
- `ALU_RESULT` in 8: combinational ALU result.

## Operation
States:
- IDLE: on `CMD_VALID & CMD_READY`, latch op, operands and set-flags bit.
  - Op 7 goes to RESP with `RSP_ERR`=1 and `RSP_DATA`=0.
  - MUL goes to MUL_ITER.
  - Any other op goes to EXEC.
- EXEC: one cycle with exactly one strobe high. Operand mapping:
  - ADD/OR/AND: `ALU_ACC`=A, `ALU_REG`=B.
  - SUB/CMP: the ALU computes REG−ACC, so `ALU_ACC`=B, `ALU_REG`=A, giving A−B mod 256.
  - SHR: `ALU_REG`=A, giving A>>1.
  - `ALU_SETFLAGS` = latched set-flags bit, forced to 1 for CMP.
  - `ALU_RESULT` is captured into `RSP_DATA`; next state is RESP.
- MUL_ITER: 8 cycles, i = 0..7.
  - Drive `ALU_ADD`=1, `ALU_ACC`=partial product P (reset to 0 at accept), `ALU_REG`=A<<i truncated to 8 bits.
  - If B[i] is set, P ← `ALU_RESULT`.
  - `ALU_SETFLAGS`=0 throughout.
- MUL_FIN: one cycle.
  - Drive `ALU_ADD`=1, `ALU_ACC`=P, `ALU_REG`=0, `ALU_SETFLAGS`=latched bit.
  - Flags therefore reflect the final product. Capture the result; next state is RESP.
- RESP: hold `RSP_VALID`=1 and `RSP_DATA`, `RSP_WE`, `RSP_ERR` stable until `RSP_READY`, then return to IDLE.

Rules:
- All strobes and ALU operands are 0 in IDLE and RESP.
- Product is the low 8 bits of A×B; no overflow reporting.
- `CMD_READY` is combinational on state (IDLE) only. A command offered while busy waits; no queueing.
- Reset is asynchronous at any point, including mid-MUL:
  - return to IDLE immediately;
  - all outputs go to 0 except `CMD_READY`=1;
  - no further `ALU_SETFLAGS` pulse is issued.

## Timing
- Accept at edge t (cycle t).
- Single-cycle op: EXEC in t+1, `RSP_VALID` from t+2.
- MUL: iterations t+1..t+8, FIN t+9, `RSP_VALID` from t+10.
- Error: `RSP_VALID` from t+1.
- Response handshake completes at an edge with `RSP_VALID & RSP_READY`. The next command can be accepted in the following cycle at the earliest, because `CMD_READY` is low in RESP.
- The ALU flag register updates on the edge ending the EXEC or FIN cycle.
- All outputs are registered or decoded from registered state. No combinational path from `CMD_*` or `RSP_READY` to outputs, except `CMD_READY` (state only).

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL (op 6) behaves as above.
- Undefined:
  - op 6 is treated like op 7 (`RSP_ERR`=1, response at t+1);
  - MUL_ITER/MUL_FIN and the partial-product/shift/bit-index registers are not built.

## Structure
- `alu_seq_pkg` holds:
  - opcode localparams `OP_ADD`..`OP_RSVD`;
  - state encoding IDLE/EXEC/MUL_ITER/MUL_FIN/RESP;
  - `MUL_ITERS`=8.
- One sub-module, `alu_seq_mul_iter`: holds P, the shifted A, and the 3-bit bit index, and signals the last iteration. It is instantiated only under `ALU_SEQ_MUL_EN`.

## Test plan
- ADD, A=0x3C, B=0x05, set-flags=1 → `ALU_ADD` high for one cycle at t+1, `ALU_SETFLAGS` high, `RSP_DATA`=0x41, `RSP_WE`=1, `RSP_VALID` at t+2.
- SUB, A=0x10, B=0x03 → `ALU_ACC`=0x03, `ALU_REG`=0x10, `ALU_SUB`=1, `RSP_DATA`=0x0D. Then CMP with same operands → `ALU_SETFLAGS`=1, `RSP_WE`=0.
- MUL, A=0x0D, B=0x0B → `RSP_DATA`=0x8F at t+10; `ALU_SETFLAGS` high only in t+9. A=0xFF, B=0xFF → 0x01.
- Backpressure: hold `RSP_READY`=0 for 3 cycles after an AND of 0xF0&0x3C → `RSP_DATA`=0x30 stable, `CMD_READY`=0, a second command is not accepted until the cycle after the handshake.
- Op 7 (and op 6 without the macro) → `RSP_ERR`=1, `RSP_DATA`=0, `RSP_VALID` at t+1, no ALU strobes.
- Assert `RST_N`=0 during MUL iteration 4 → all outputs 0 asynchronously, `CMD_READY`=1 after release, no `ALU_SETFLAGS` pulse, next ADD behaves normally.
